// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed data memory load/store unit.
package dmem_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Load/store request and response bundle between the MEM stage and the data memory.
interface dmem_lsu_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_busy;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );
endinterface

// File: rtl/dmem_load_align.sv
// Moves the addressed byte/half of a memory word down to bit 0 and extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [4:0]  sh_amt;
  logic [31:0] shifted;

  assign sh_amt  = {lane_i, 3'b000};
  assign shifted = word_i >> sh_amt;

  always_comb begin
    data_o = shifted;
    case (size_i)
      SZ_BYTE: data_o = unsigned_i ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: data_o = unsigned_i ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Single-port byte-addressed data memory with 1-cycle responses and post-reset clear.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH          = 512,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic       clk,
  input logic       rst,
  dmem_lsu_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(DEPTH);
  localparam int unsigned HI_W  = ADDR_W - 2;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             clr_we;
  logic             rsp_valid_q;
  rsp_t             rsp_q, rsp_d;

  logic [31:0]      mem [DEPTH];

  logic [HI_W-1:0]  word_hi;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             acc, acc_err, size_err, range_err, st_we;
  logic [3:0]       lane_mask;
  logic [31:0]      bit_mask, wdata_sh, rd_word, merged, ld_data;

  // Request decode
  assign acc       = bus.req_valid & ready_q;
  assign word_hi   = bus.req_addr[ADDR_W-1:2];
  assign idx       = word_hi[IDX_W-1:0];
  assign lane      = bus.req_addr[1:0];
  assign range_err = (word_hi >= HI_W'(DEPTH));
  assign acc_err   = size_err | range_err;
  assign st_we     = acc & bus.req_we & ~acc_err;

  always_comb begin
    size_err  = 1'b0;
    lane_mask = 4'b1111;
    case (bus.req_size)
      SZ_BYTE: lane_mask = 4'b0001 << lane;
      SZ_HALF: begin
        size_err  = lane[0];
        lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: size_err = |lane;
      default: size_err = 1'b1;
    endcase
  end

  // Store merge: only the addressed lanes take new data
  assign bit_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
  assign wdata_sh = bus.req_wdata << {lane, 3'b000};
  assign rd_word  = mem[idx];
  assign merged   = (rd_word & ~bit_mask) | (wdata_sh & bit_mask);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else if (st_we) begin
      mem[idx] <= merged;
    end
  end

  dmem_load_align u_align (
    .word_i     (rd_word),
    .lane_i     (lane),
    .size_i     (bus.req_size),
    .unsigned_i (bus.req_unsigned),
    .data_o     (ld_data)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(DEPTH - 1)) begin
        state_d = IDLE;
      end
    end
  end

  // FSM outputs
  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b0;
    clr_we  = 1'b0;
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == CLEAR);
    clr_we  = (state_q == CLEAR);
  end

  always_comb begin
    rsp_d = '0;
    if (acc) begin
      rsp_d.err = acc_err;
      if (!bus.req_we && !acc_err) begin
        rsp_d.rdata = ld_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      rsp_valid_q <= acc;
      rsp_q       <= rsp_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.init_busy = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_q.err;
  assign bus.rsp_rdata = rsp_q.rdata;

endmodule
